// File: rtl/axi_mport_aw_arbiter_if.sv
// Bus bundle for the per-master-port AW arbiter: slave-port AW requests, the master AW
// handshake, W-mux routing and B retirement. "master" is the arbiter's view.
interface axi_mport_aw_arbiter_if #(
  parameter int S_COUNT     = 4,
  parameter int ISSUE_LIMIT = 4,
  parameter int SEL_W       = $clog2(S_COUNT),
  parameter int CNT_W       = $clog2(ISSUE_LIMIT + 1)
);
  logic [S_COUNT-1:0]   s_req;
  logic [S_COUNT*4-1:0] s_qos;
  logic [S_COUNT-1:0]   s_ack;
  logic                 m_awvalid;
  logic                 m_awready;
  logic [SEL_W-1:0]     m_sel;
  logic [SEL_W-1:0]     w_sel;
  logic                 w_sel_valid;
  logic                 w_last_done;
  logic                 b_done;
  logic [CNT_W-1:0]     outstanding;
  logic                 err_underflow;

  modport master (
    input  s_req, s_qos, m_awready, w_last_done, b_done,
    output s_ack, m_awvalid, m_sel, w_sel, w_sel_valid, outstanding, err_underflow
  );

  modport slave (
    output s_req, s_qos, m_awready, w_last_done, b_done,
    input  s_ack, m_awvalid, m_sel, w_sel, w_sel_valid, outstanding, err_underflow
  );
endinterface

// File: rtl/axi_mport_aw_arbiter.sv
// AW arbiter and W-order sequencer for one interconnect master port.
// Optional macro AXI_AW_QOS_ARB_EN: QoS-priority arbitration; otherwise pure round-robin.
module axi_mport_aw_arbiter #(
  parameter int S_COUNT     = 4,
  parameter int ISSUE_LIMIT = 4,
  parameter int WFIFO_DEPTH = 4,
  parameter int SEL_W       = $clog2(S_COUNT),
  parameter int CNT_W       = $clog2(ISSUE_LIMIT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  axi_mport_aw_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(WFIFO_DEPTH);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(ISSUE_LIMIT);
  localparam logic [PTR_W:0]   DEPTH    = (PTR_W + 1)'(WFIFO_DEPTH);
  localparam logic [SEL_W-1:0] LAST_SRC = SEL_W'(S_COUNT - 1);

  logic [0:0]       state;
  logic [SEL_W-1:0] m_sel_q;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_next;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] win_idx;
  logic             win_found;
  logic             grant;
  logic             aw_accept;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [CNT_W-1:0] outstanding_q;
  logic             err_q;

  logic [SEL_W-1:0] fifo_mem [WFIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   fifo_count;

`ifdef AXI_AW_QOS_ARB_EN
  logic [3:0] best_qos;

  // Scan from rr_ptr upward; strict '>' keeps the earliest candidate on a QoS tie.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    best_qos  = '0;
    cand      = '0;
    for (int k = 0; k < S_COUNT; k++) begin
      cand = SEL_W'((int'(rr_ptr) + k) % S_COUNT);
      if (bus.s_req[cand] && (!win_found || (bus.s_qos[4*int'(cand) +: 4] > best_qos))) begin
        win_found = 1'b1;
        win_idx   = cand;
        best_qos  = bus.s_qos[4*int'(cand) +: 4];
      end
    end
  end
`else
  logic unused_qos;
  assign unused_qos = ^bus.s_qos;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < S_COUNT; k++) begin
      cand = SEL_W'((int'(rr_ptr) + k) % S_COUNT);
      if (bus.s_req[cand] && !win_found) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  // Grant only when both the issue budget and a W-routing slot are free, so pushes never overflow.
  assign grant      = (state == ST_ARB) && win_found && (outstanding_q < LIMIT) && (fifo_count < DEPTH);
  assign aw_accept  = (state == ST_HOLD) && bus.m_awready;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_pop   = bus.w_last_done && !fifo_empty;
  assign rr_next    = (m_sel_q == LAST_SRC) ? '0 : m_sel_q + 1'b1;

  assign bus.m_awvalid     = (state == ST_HOLD);
  assign bus.m_sel         = m_sel_q;
  assign bus.s_ack         = aw_accept ? (S_COUNT'(1) << m_sel_q) : '0;
  assign bus.w_sel         = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign bus.w_sel_valid   = !fifo_empty;
  assign bus.outstanding   = outstanding_q;
  assign bus.err_underflow = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ARB;
      m_sel_q <= '0;
      rr_ptr  <= '0;
    end else begin
      case (state)
        ST_ARB: begin
          if (grant) begin
            m_sel_q <= win_idx;
            state   <= ST_HOLD;
          end
        end
        default: begin
          if (bus.m_awready) begin
            rr_ptr <= rr_next;
            state  <= ST_ARB;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (aw_accept) begin
      fifo_mem[wr_ptr] <= m_sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (aw_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (aw_accept && !fifo_pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (fifo_pop && !aw_accept) begin
        fifo_count <= fifo_count - 1'b1;
      end
    end
  end

  // An accept and a retirement in the same cycle cancel; retiring from zero only flags the error.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      if (aw_accept && !bus.b_done) begin
        outstanding_q <= outstanding_q + 1'b1;
      end else if (bus.b_done && !aw_accept && (outstanding_q != '0)) begin
        outstanding_q <= outstanding_q - 1'b1;
      end
      if ((bus.b_done && !aw_accept && (outstanding_q == '0)) || (bus.w_last_done && fifo_empty)) begin
        err_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_axi_mport_aw_arbiter.sv
// Testbench for axi_mport_aw_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_axi_mport_aw_arbiter;
  localparam int S_COUNT     = 4;
  localparam int ISSUE_LIMIT = 4;
  localparam int WFIFO_DEPTH = 4;
`ifdef AXI_AW_QOS_ARB_EN
  localparam bit QOS_EN = 1'b1;
`else
  localparam bit QOS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_mport_aw_arbiter_if #(.S_COUNT(S_COUNT), .ISSUE_LIMIT(ISSUE_LIMIT)) bus ();

  axi_mport_aw_arbiter #(
    .S_COUNT(S_COUNT), .ISSUE_LIMIT(ISSUE_LIMIT), .WFIFO_DEPTH(WFIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: transaction-level view of the arbiter.
  bit mdl_valid = 1'b0;
  bit mdl_hold;
  int mdl_sel;
  int mdl_rr;
  int mdl_out;
  bit mdl_err;
  int mdl_fifo[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_winner(input logic [3:0] req, input logic [15:0] qos);
    int best;
    int w;
    int i;
    int pri;
    best = -1;
    w    = -1;
    for (int k = 0; k < S_COUNT; k++) begin
      i   = (mdl_rr + k) % S_COUNT;
      pri = QOS_EN ? int'(qos[4*i +: 4]) : 0;
      if (req[i] && (w < 0 || pri > best)) begin
        best = pri;
        w    = i;
      end
    end
    return w;
  endfunction

  task automatic model_step(input bit r, input logic [3:0] req, input logic [15:0] qos,
                            input bit rdy, input bit wl, input bit bd);
    bit accept;
    int out_pre;
    int size_pre;
    int w;
    if (r) begin
      mdl_hold  = 1'b0;
      mdl_sel   = 0;
      mdl_rr    = 0;
      mdl_out   = 0;
      mdl_err   = 1'b0;
      mdl_fifo.delete();
      mdl_valid = 1'b1;
      return;
    end
    accept   = mdl_hold && rdy;
    out_pre  = mdl_out;
    size_pre = mdl_fifo.size();
    if (wl) begin
      if (size_pre == 0) mdl_err = 1'b1;
      else void'(mdl_fifo.pop_front());
    end
    if (accept && !bd) mdl_out++;
    else if (bd && !accept) begin
      if (mdl_out == 0) mdl_err = 1'b1;
      else mdl_out--;
    end
    if (!mdl_hold) begin
      w = pick_winner(req, qos);
      if (w >= 0 && out_pre < ISSUE_LIMIT && size_pre < WFIFO_DEPTH) begin
        mdl_hold = 1'b1;
        mdl_sel  = w;
      end
    end else if (accept) begin
      mdl_fifo.push_back(mdl_sel);
      mdl_rr   = (mdl_sel + 1) % S_COUNT;
      mdl_hold = 1'b0;
    end
  endtask

  task automatic checkOutput(input bit rdy);
    check_val("m_awvalid", 32'(bus.m_awvalid), 32'(mdl_hold));
    check_val("s_ack", 32'(bus.s_ack), 32'((mdl_hold && rdy) ? (1 << mdl_sel) : 0));
    if (mdl_hold) check_val("m_sel", 32'(bus.m_sel), 32'(mdl_sel));
    check_val("w_sel_valid", 32'(bus.w_sel_valid), 32'(mdl_fifo.size() != 0));
    if (mdl_fifo.size() != 0) check_val("w_sel", 32'(bus.w_sel), 32'(mdl_fifo[0]));
    check_val("outstanding", 32'(bus.outstanding), 32'(mdl_out));
    check_val("err_underflow", 32'(bus.err_underflow), 32'(mdl_err));
  endtask

  // One cycle: drive at the falling edge, compare outputs, then advance the model over the next rising edge.
  task automatic applyStimulus(input bit r, input logic [3:0] req, input logic [15:0] qos,
                               input bit rdy, input bit wl, input bit bd);
    @(negedge clk);
    rst             = r;
    bus.s_req       = req;
    bus.s_qos       = qos;
    bus.m_awready   = rdy;
    bus.w_last_done = wl;
    bus.b_done      = bd;
    #1;
    if (mdl_valid) checkOutput(rdy);
    model_step(r, req, qos, rdy, wl, bd);
  endtask

  task automatic do_grant(input logic [3:0] req, input logic [15:0] qos, input bit bd, input int exp_sel,
                          input string tag);
    applyStimulus(1'b0, req, qos, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, qos, 1'b1, 1'b0, bd);
    check_val(tag, 32'(bus.m_sel), 32'(exp_sel));
  endtask

  initial begin
    logic [3:0]  rq;
    logic [15:0] qs;
    bit          r, rdy, wl, bd;
    int          accepts;
    bit          seen;
    int          first_sel;
    int          second_sel;

    bus.s_req       = '0;
    bus.s_qos       = '0;
    bus.m_awready   = 1'b0;
    bus.w_last_done = 1'b0;
    bus.b_done      = 1'b0;

    $display("[TB] test 1: single grant after reset");
    applyStimulus(1'b1, 4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0001, 16'h0, 1'b1, 1'b0, 1'b0);
    check_val("t1_reset_m_sel", 32'(bus.m_sel), 32'd0);
    check_val("t1_awvalid_cyc1", 32'(bus.m_awvalid), 32'd0);
    applyStimulus(1'b0, 4'b0000, 16'h0, 1'b1, 1'b0, 1'b0);
    check_val("t1_awvalid_cyc2", 32'(bus.m_awvalid), 32'd1);
    check_val("t1_s_ack", 32'(bus.s_ack), 32'b0001);
    applyStimulus(1'b0, 4'b0000, 16'h0, 1'b1, 1'b0, 1'b0);
    check_val("t1_s_ack_after", 32'(bus.s_ack), 32'd0);
    check_val("t1_w_sel_valid", 32'(bus.w_sel_valid), 32'd1);
    check_val("t1_w_sel", 32'(bus.w_sel), 32'd0);
    check_val("t1_outstanding", 32'(bus.outstanding), 32'd1);

    $display("[TB] test 2: round-robin over four equal requesters");
    applyStimulus(1'b1, 4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < 4; g++) do_grant(4'b1111, 16'h0, 1'b1, g, "t2_rr_grant");
    for (int g = 0; g < 4; g++) begin
      applyStimulus(1'b0, 4'b0000, 16'h0, 1'b0, 1'b1, 1'b0);
      check_val("t2_w_sel_order", 32'(bus.w_sel), 32'(g));
    end
    do_grant(4'b1111, 16'h0, 1'b1, 0, "t2_rr_wrap");
    check_val("t2_outstanding", 32'(bus.outstanding), 32'd0);

    $display("[TB] test 3: QoS priority");
    applyStimulus(1'b1, 4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
    first_sel  = QOS_EN ? 2 : 1;
    second_sel = QOS_EN ? 1 : 2;
    do_grant(4'b0110, 16'h0920, 1'b0, first_sel, "t3_first");
    do_grant(QOS_EN ? 4'b0010 : 4'b0100, 16'h0920, 1'b0, second_sel, "t3_second");

    $display("[TB] test 4: issue limit");
    applyStimulus(1'b1, 4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
    accepts = 0;
    for (int c = 0; c < 14; c++) begin
      applyStimulus(1'b0, 4'b0001, 16'h0, 1'b1, mdl_fifo.size() != 0, 1'b0);
      if (bus.s_ack[0] === 1'b1) accepts++;
    end
    check_val("t4_accepts", 32'(accepts), 32'd4);
    check_val("t4_outstanding", 32'(bus.outstanding), 32'd4);
    check_val("t4_awvalid_blocked", 32'(bus.m_awvalid), 32'd0);
    applyStimulus(1'b0, 4'b0001, 16'h0, 1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 4'b0001, 16'h0, 1'b0, 1'b0, 1'b0);
      if (bus.m_awvalid === 1'b1) seen = 1'b1;
    end
    check_val("t4_regrant_within_2", 32'(seen), 32'd1);
    applyStimulus(1'b0, 4'b0000, 16'h0, 1'b1, 1'b0, 1'b0);

    $display("[TB] test 5: simultaneous accept/retire and underflow");
    applyStimulus(1'b1, 4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
    do_grant(4'b0001, 16'h0, 1'b0, 0, "t5_grant_a");
    do_grant(4'b0001, 16'h0, 1'b0, 0, "t5_grant_b");
    do_grant(4'b0001, 16'h0, 1'b1, 0, "t5_grant_c");
    applyStimulus(1'b0, 4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
    check_val("t5_out_same_cycle", 32'(bus.outstanding), 32'd2);
    check_val("t5_no_err_yet", 32'(bus.err_underflow), 32'd0);
    applyStimulus(1'b0, 4'b0000, 16'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 16'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 16'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
    check_val("t5_err_underflow", 32'(bus.err_underflow), 32'd1);
    check_val("t5_out_zero", 32'(bus.outstanding), 32'd0);

    $display("[TB] test 6: reset during HOLD");
    applyStimulus(1'b0, 4'b0001, 16'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
    check_val("t6_in_hold", 32'(bus.m_awvalid), 32'd1);
    check_val("t6_fifo_valid", 32'(bus.w_sel_valid), 32'd1);
    applyStimulus(1'b1, 4'b0000, 16'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 16'h0, 1'b1, 1'b0, 1'b0);
    check_val("t6_awvalid", 32'(bus.m_awvalid), 32'd0);
    check_val("t6_w_sel_valid", 32'(bus.w_sel_valid), 32'd0);
    check_val("t6_outstanding", 32'(bus.outstanding), 32'd0);
    check_val("t6_s_ack", 32'(bus.s_ack), 32'd0);
    check_val("t6_err_cleared", 32'(bus.err_underflow), 32'd0);

    $display("[TB] random traffic");
    for (int n = 0; n < 800; n++) begin
      rq  = 4'($urandom);
      qs  = 16'($urandom);
      r   = ($urandom_range(0, 99) < 2);
      rdy = $urandom_range(0, 1) == 1;
      wl  = ((mdl_fifo.size() != 0) && ($urandom_range(0, 99) < 40)) || ($urandom_range(0, 99) < 2);
      bd  = ((mdl_out != 0) && ($urandom_range(0, 99) < 40)) || ($urandom_range(0, 99) < 2);
      applyStimulus(r, rq, qs, rdy, wl, bd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
